// File: rtl/prll_shift_reg.sv
// ============================================================================
// Module   : prll_shift_reg
// Purpose  : Parallel-load / bidirectional serial-shift register with shift
//            counter and completion pulse (UART TX serialiser / RX deserialiser).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module prll_shift_reg #(
   parameter int BITS  = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift_en,
   input  logic             dir,
   input  logic             serial_in,
   input  logic [BITS-1:0]  D_in,
   output logic [BITS-1:0]  D_out,
   output logic             serial_out,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      FULL   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BITS - 1);
   localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

   state_t           state_q, state_d;
   logic [BITS-1:0]  data_q,  data_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             done_q,  done_d;
   logic [BITS-1:0]  shifted;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      shifted = dir ? {data_q[BITS-2:0], serial_in}
                    : {serial_in, data_q[BITS-1:1]};
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      if (load) begin
         // A simultaneous shift strobe is dropped: load always wins.
         data_d  = D_in;
         cnt_d   = '0;
         state_d = ACTIVE;
      end else if (shift_en) begin
         data_d = shifted;
         if (state_q == FULL) begin
            cnt_d   = C_ONE;
            state_d = ACTIVE;
         end else if (cnt_q == C_LAST) begin
            cnt_d   = cnt_q + C_ONE;
            state_d = FULL;
            done_d  = 1'b1;
         end else begin
            cnt_d   = cnt_q + C_ONE;
            state_d = ACTIVE;
         end
      end
   end

   assign D_out      = data_q;
   assign shift_cnt  = cnt_q;
   assign busy       = (state_q == ACTIVE);
   assign done       = done_q;
   assign serial_out = dir ? data_q[BITS-1] : data_q[0];

endmodule

`default_nettype wire

// File: doc/prll_shift_reg.md
Name: prll_shift_reg

Overview:
- Parametrised parallel-load / bidirectional serial-shift register for the UART datapath.
- Generalises the plain parallel D register with:
  - parallel load
  - right shift (LSB-first, UART order) and left shift
  - hold
  - a shift counter and a one-cycle completion pulse
- Used as the TX serialiser (load word, shift out) and the RX deserialiser (shift in, read word).

Parameters:
- bits, 8, register width in bits (≥2).
- cnt_w, 4, shift counter width; must satisfy 2^cnt_w > bits.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- load  input  1  parallel-load strobe.
- shift_en  input  1  shift-one-position strobe.
- dir  input  1  shift direction: 0 = right (toward bit 0), 1 = left.
- serial_in  input  1  bit shifted into the vacated end.
- D_in  input  bits  parallel load data.
- D_out  output  bits  current register contents.
- serial_out  output  1  bit that the next shift will eject.
- shift_cnt  output  cnt_w  shifts performed since last load or reset.
- busy  output  1  high while in ACTIVE state.
- done  output  1  one-cycle pulse when the bits-th shift completes.

Behaviour:
- Reset (reset == 0 at rising edge) overrides every other input. Values after reset:
  - D_out = 0, shift_cnt = 0, busy = 0, done = 0, state = IDLE.
  - A reset mid-shift aborts immediately. No done pulse is issued.
- State machine:
  - States: IDLE, ACTIVE, FULL.
  - IDLE --load--> ACTIVE.
  - IDLE --shift_en--> ACTIVE. Shifting starts from the current contents, which supports the RX use with no prior load.
  - ACTIVE --shift_en with shift_cnt == bits-1--> FULL.
  - FULL --load--> ACTIVE.
  - FULL --shift_en--> ACTIVE. The counter restarts at 1 and the register keeps shifting.
- Priority per cycle: reset > load > shift_en > hold.
- load:
  - D_out <= D_in, shift_cnt <= 0, state <= ACTIVE.
  - If shift_en is also high that cycle, it is ignored: no shift and no count.
- shift_en, dir = 0:
  - D_out <= {serial_in, D_out[bits-1:1]}.
  - shift_cnt increments.
- shift_en, dir = 1:
  - D_out <= {D_out[bits-2:0], serial_in}.
  - shift_cnt increments.
- dir is sampled only in cycles where shift_en is high. It may change between shifts.
- serial_out:
  - Combinational from the current register: D_out[0] when dir = 0, D_out[bits-1] when dir = 1.
  - Valid the same cycle, zero latency.
- Latency: D_out, shift_cnt, busy and done all update on the rising edge following the strobe.
- shift_cnt:
  - Saturates logically at bits: the cycle it reaches bits, state becomes FULL.
  - A further shift wraps it to 1. It never exceeds bits.
- done:
  - Registered; high for exactly the one cycle after the shift that brings shift_cnt to bits.
  - If load arrives in that same cycle, done still goes high because it reflects the previous edge's completion.
- busy: high iff state == ACTIVE.
- Hold (no load, no shift_en): all registers keep their values and done returns to 0.

Test Plan:
- Reset: drive random inputs and hold reset = 0 for 2 cycles. Required: D_out = 0x00, shift_cnt = 0, busy = 0, done = 0. Releasing reset with no strobes leaves all outputs unchanged.
- TX right shift (bits = 8): load with D_in = 0xA5, then 8 cycles of shift_en with dir = 0 and serial_in = 1.
  - serial_out sequence is 1,0,1,0,0,1,0,1.
  - Final D_out = 0xFF, shift_cnt = 8.
  - done is high for exactly one cycle after the 8th shift; busy = 0 afterwards.
- RX left shift: from reset, 8 shifts with dir = 1 and serial_in sequence 1,1,0,0,1,0,1,0.
  - D_out = 0xCA.
  - done pulses once; state goes IDLE→ACTIVE→FULL.
- Load/shift collision: after D_out = 0x3C, assert load with D_in = 0x81 and shift_en together.
  - D_out = 0x81, shift_cnt = 0 — no shift.
- Reset mid-operation: load 0xF0, do 4 right shifts, then assert reset = 0 for one cycle.
  - D_out = 0, shift_cnt = 0, busy = 0.
  - done never pulses.
- Wrap from FULL: after a completed 8-shift, apply one more shift with dir = 0 and serial_in = 0.
  - shift_cnt = 1, busy = 1, done = 0.
  - D_out is shifted right by one.
